// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// Signals:
//   start        - request an addition (driven by the requester)
//   A, B, Cin    - operands and carry-in, captured when start is accepted
//   busy         - high while operand bits are being consumed
//   done         - one-cycle pulse when Sum/Cout are updated
//   Sum, Cout    - result of the last completed addition
// Modports: master = requester side, slave = adder side.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;

    modport master (
        output start, A, B, Cin,
        input  busy, done, Sum, Cout
    );

    modport slave (
        input  start, A, B, Cin,
        output busy, done, Sum, Cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: sums two WIDTH-bit operands LSB-first, one bit per clock.
// A full adder is formed from two half_adder instances plus an OR of their
// carries; the running carry lives in a flip-flop between bit times.
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous, active-high reset
//   bus - serial_adder_if slave modport (start/A/B/Cin in, busy/done/Sum/Cout out)
// Timing: start accepted on edge 0, SHIFT on edges 1..WIDTH, done high in the
// cycle after edge WIDTH, then one IDLE cycle before the next accept.

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   a_sr_r;
    logic [WIDTH-1:0]   b_sr_r;
    logic [WIDTH-1:0]   s_sr_r;
    logic               c_ff_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               busy_r;
    logic               done_r;

    logic               ha0_s_s;
    logic               ha0_c_s;
    logic               sum_bit_s;
    logic               ha1_c_s;
    logic               carry_s;
    logic [WIDTH-1:0]   s_next_s;

    // Full adder on the current LSBs and the stored carry
    half_adder u_ha0 (
        .a (a_sr_r[0]),
        .b (b_sr_r[0]),
        .s (ha0_s_s),
        .c (ha0_c_s)
    );

    half_adder u_ha1 (
        .a (ha0_s_s),
        .b (c_ff_r),
        .s (sum_bit_s),
        .c (ha1_c_s)
    );

    assign carry_s = ha0_c_s | ha1_c_s;

    // New sum bit enters at the MSB; the shift keeps this legal for WIDTH = 1
    assign s_next_s = WIDTH'({sum_bit_s, s_sr_r} >> 1);

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, bit-serial datapath and registered status/result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr_r <= '0;
            b_sr_r <= '0;
            s_sr_r <= '0;
            c_ff_r <= 1'b0;
            cnt_r  <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            // busy/done track the state being entered, so they align with state_r
            busy_r <= (state_s == ST_SHIFT);
            done_r <= (state_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sr_r <= bus.A;
                        b_sr_r <= bus.B;
                        c_ff_r <= bus.Cin;
                        cnt_r  <= '0;
                    end else begin
                        cnt_r  <= cnt_r;
                    end
                end
                ST_SHIFT: begin
                    c_ff_r <= carry_s;
                    s_sr_r <= s_next_s;
                    a_sr_r <= a_sr_r >> 1;
                    b_sr_r <= b_sr_r >> 1;
                    cnt_r  <= cnt_r + CNT_W'(1);
                    // Results are published only once complete, never partially
                    if (cnt_r == CNT_LAST) begin
                        sum_r  <= s_next_s;
                        cout_r <= carry_s;
                    end else begin
                        sum_r  <= sum_r;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.Sum  = sum_r;
    assign bus.Cout = cout_r;
endmodule
